// File: rtl/gfg_register_bank.sv
// Register bank behind gfg_spi_slave: ID/CTRL/CMD/STATUS registers plus shadow
// parameters that reach the core only through a busy-deferred commit.
module gfg_register_bank #(
  parameter int                        NUM_REGISTERS  = 32,
  parameter int                        REGISTER_WIDTH = 32,
  parameter int                        NUM_PARAMS     = 12,
  parameter logic [REGISTER_WIDTH-1:0] ID_VALUE       = 32'h6766_0001
) (
  input  logic                                 i_sys_clk,
  input  logic                                 i_arst_n,
  input  logic [$clog2(NUM_REGISTERS)-1:0]     i_reg_addr,
  input  logic [REGISTER_WIDTH-1:0]            i_reg_write_data,
  input  logic                                 i_reg_write_en,
  output logic [REGISTER_WIDTH-1:0]            o_reg_read_data,
  input  logic                                 i_busy,
  input  logic                                 i_error_pulse,
  output logic                                 o_enable,
  output logic [NUM_PARAMS*REGISTER_WIDTH-1:0] o_active_params,
  output logic                                 o_commit_pulse,
  output logic                                 o_soft_rst_pulse
);

  localparam int AW = $clog2(NUM_REGISTERS);
  localparam int W  = REGISTER_WIDTH;

  localparam logic [AW-1:0] ADDR_ID     = AW'(0);
  localparam logic [AW-1:0] ADDR_CTRL   = AW'(1);
  localparam logic [AW-1:0] ADDR_CMD    = AW'(2);
  localparam logic [AW-1:0] ADDR_STATUS = AW'(3);
  localparam int            SHADOW_BASE = 4;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [W-1:0] ctrl;
  logic [W-1:0] shadow [NUM_PARAMS];
  logic         err;
  logic [0:0]   state;

  logic cmd_wr;
  logic ctrl_wr;
  logic status_wr;
  logic commit_now;

  assign cmd_wr     = i_reg_write_en && (i_reg_addr == ADDR_CMD);
  assign ctrl_wr    = i_reg_write_en && (i_reg_addr == ADDR_CTRL);
  assign status_wr  = i_reg_write_en && (i_reg_addr == ADDR_STATUS);
  assign commit_now = (state == ST_PENDING) && !i_busy;

  assign o_enable = ctrl[0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_sys_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ctrl <= '0;
    end else if (ctrl_wr) begin
      ctrl <= i_reg_write_data;
    end
  end

  // NOTE: the shadow array is a register file that must read 0 after reset, so it is reset element by element.
  always_ff @(posedge i_sys_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < NUM_PARAMS; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (i_reg_write_en && (i_reg_addr == AW'(SHADOW_BASE + i))) shadow[i] <= i_reg_write_data;
      end
    end
  end

  // A request arriving while already pending is absorbed into the pending commit.
  always_ff @(posedge i_sys_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (cmd_wr && i_reg_write_data[0]) state <= ST_PENDING;
        ST_PENDING: if (!i_busy) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_active_params  <= '0;
      o_commit_pulse   <= 1'b0;
      o_soft_rst_pulse <= 1'b0;
    end else begin
      o_commit_pulse   <= commit_now;
      o_soft_rst_pulse <= cmd_wr && i_reg_write_data[1];
      if (commit_now) begin
        for (int i = 0; i < NUM_PARAMS; i++) o_active_params[i*W +: W] <= shadow[i];
      end
    end
  end

  // Error set has priority over a coincident write-1-to-clear.
  always_ff @(posedge i_sys_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      err <= 1'b0;
    end else if (i_error_pulse) begin
      err <= 1'b1;
    end else if (status_wr && i_reg_write_data[1]) begin
      err <= 1'b0;
    end
  end

  // NOTE: the read mux assigns a default first so no path through it infers a latch.
  always_comb begin
    o_reg_read_data = '0;
    case (i_reg_addr)
      ADDR_ID:     o_reg_read_data = ID_VALUE;
      ADDR_CTRL:   o_reg_read_data = ctrl;
      ADDR_STATUS: o_reg_read_data = {{(W-3){1'b0}}, (state == ST_PENDING), err, i_busy};
      default:     o_reg_read_data = '0;
    endcase
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (i_reg_addr == AW'(SHADOW_BASE + i)) o_reg_read_data = shadow[i];
    end
  end

endmodule
